// File: rtl/pq_share_ctrl_if.sv
// pq_share_ctrl_if: bundles the two requester channels, the tagged response
// channel and the priority-queue command/status bus used by pq_share_ctrl.
//
// Signals (directions as seen by the controller, i.e. the slave modport):
//   a_valid_i/a_op_i/a_data_i -> a_ready_o   requester A (op 0 = push, 1 = pop)
//   b_valid_i/b_op_i/b_data_i -> b_ready_o   requester B
//   rsp_valid_o/rsp_id_o/rsp_err_o/rsp_data_o  one-cycle tagged response
//   pq_cmd_o   {op[1:0], entry} to the queue (00 NOP, 01 INSERT, 10 DELETE-MIN)
//   pq_st_i    queue state, pq_head_i {valid, head entry}
//   count_o    current occupancy
// The master modport is the mirror image, used by the requester/queue side.
interface pq_share_ctrl_if #(
    parameter int unsigned EW = 65,
    parameter int unsigned CW = 10
);
    logic          a_valid_i;
    logic          a_op_i;
    logic [EW-1:0] a_data_i;
    logic          a_ready_o;

    logic          b_valid_i;
    logic          b_op_i;
    logic [EW-1:0] b_data_i;
    logic          b_ready_o;

    logic          rsp_valid_o;
    logic          rsp_id_o;
    logic          rsp_err_o;
    logic [EW-1:0] rsp_data_o;

    logic [EW+1:0] pq_cmd_o;
    logic [2:0]    pq_st_i;
    logic [EW:0]   pq_head_i;

    logic [CW-1:0] count_o;

    modport slave (
        input  a_valid_i, a_op_i, a_data_i,
        output a_ready_o,
        input  b_valid_i, b_op_i, b_data_i,
        output b_ready_o,
        output rsp_valid_o, rsp_id_o, rsp_err_o, rsp_data_o,
        output pq_cmd_o,
        input  pq_st_i, pq_head_i,
        output count_o
    );

    modport master (
        output a_valid_i, a_op_i, a_data_i,
        input  a_ready_o,
        output b_valid_i, b_op_i, b_data_i,
        input  b_ready_o,
        input  rsp_valid_o, rsp_id_o, rsp_err_o, rsp_data_o,
        input  pq_cmd_o,
        output pq_st_i, pq_head_i,
        input  count_o
    );
endinterface

// File: rtl/pq_share_ctrl.sv
// pq_share_ctrl: shares one priority-queue datapath between two requesters.
// Arbitrates round-robin between A and B, issues one INSERT/DELETE-MIN at a
// time, waits for the queue to return to idle (with timeout) and returns a
// tagged one-cycle response. Occupancy is tracked locally so push-when-full
// and pop-when-empty are rejected without touching the queue.
//
// Ports:
//   system1000       clock
//   system1000_rstn  asynchronous active-low reset
//   bus              pq_share_ctrl_if.slave (requesters, response, queue bus)
module pq_share_ctrl #(
    parameter int unsigned DEPTH      = 1000,
    parameter int unsigned EW         = 65,
    parameter int unsigned CW         = 10,
    parameter logic [2:0]  PQ_IDLE_ST = 3'd0,
    parameter int unsigned TIMEOUT    = 255
) (
    input logic            system1000,
    input logic            system1000_rstn,
    pq_share_ctrl_if.slave bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [1:0]    state_q, state_d;
    logic          last_b_q, last_b_d;   // 1: B was granted last
    logic          id_q, id_d;
    logic          op_q, op_d;
    logic [EW-1:0] data_q, data_d;
    logic [EW:0]   head_q, head_d;
    logic          err_q, err_d;
    logic [TW-1:0] wait_q, wait_d;
    logic [CW-1:0] count_q, count_d;

    logic          q_idle;
    logic          arb_ok;
    logic          grant_a;
    logic          grant_b;
    logic          accept;
    logic          sel_op;
    logic [EW-1:0] sel_data;
    logic          full;
    logic          empty;
    logic          rsp_err;
    logic          in_resp;

    assign q_idle  = (bus.pq_st_i == PQ_IDLE_ST);
    // Ready is gated by reset so both ready outputs read 0 while in reset.
    assign arb_ok  = (state_q == ST_IDLE) & q_idle & system1000_rstn;
    assign grant_a = bus.a_valid_i & (~bus.b_valid_i | last_b_q);
    assign grant_b = bus.b_valid_i & (~bus.a_valid_i | ~last_b_q);

    assign bus.a_ready_o = arb_ok & grant_a;
    assign bus.b_ready_o = arb_ok & grant_b;

    assign accept   = bus.a_ready_o | bus.b_ready_o;
    assign sel_op   = bus.b_ready_o ? bus.b_op_i : bus.a_op_i;
    assign sel_data = bus.b_ready_o ? bus.b_data_i : bus.a_data_i;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // A pop whose latched head was invalid is reported as an error even though
    // the queue was commanded; occupancy is left alone in that case.
    assign rsp_err = err_q | (op_q & ~head_q[EW]);
    assign in_resp = (state_q == ST_RESP);

    always_comb begin
        state_d  = state_q;
        last_b_d = last_b_q;
        id_d     = id_q;
        op_d     = op_q;
        data_d   = data_q;
        head_d   = head_q;
        err_d    = err_q;
        wait_d   = wait_q;
        count_d  = count_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    id_d     = bus.b_ready_o;
                    last_b_d = bus.b_ready_o;
                    op_d     = sel_op;
                    data_d   = sel_data;
                    head_d   = bus.pq_head_i;
                    if ((~sel_op & full) | (sel_op & empty)) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                wait_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (q_idle) begin
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (wait_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    wait_d = wait_q + TW'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                if (!rsp_err) begin
                    count_d = op_q ? (count_q - CW'(1)) : (count_q + CW'(1));
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state_q  <= ST_IDLE;
            last_b_q <= 1'b1;
            id_q     <= 1'b0;
            op_q     <= 1'b0;
            data_q   <= '0;
            head_q   <= '0;
            err_q    <= 1'b0;
            wait_q   <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            last_b_q <= last_b_d;
            id_q     <= id_d;
            op_q     <= op_d;
            data_q   <= data_d;
            head_q   <= head_d;
            err_q    <= err_d;
            wait_q   <= wait_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        bus.pq_cmd_o = '0;
        if (state_q == ST_ISSUE) begin
            bus.pq_cmd_o = op_q ? {2'b10, {EW{1'b0}}} : {2'b01, data_q};
        end
    end

    assign bus.rsp_valid_o = in_resp;
    assign bus.rsp_id_o    = in_resp & id_q;
    assign bus.rsp_err_o   = in_resp & rsp_err;
    assign bus.rsp_data_o  = (in_resp & ~rsp_err) ? (op_q ? head_q[EW-1:0] : data_q) : '0;
    assign bus.count_o     = count_q;

endmodule

// File: tb/tb_pq_share_ctrl.sv
`timescale 1ns/1ps
module tb_pq_share_ctrl;
    localparam int unsigned DEPTH   = 1000;
    localparam int unsigned EW      = 65;
    localparam int unsigned CW      = 10;
    localparam int unsigned TIMEOUT = 255;
    localparam logic [2:0]  IDLE_ST = 3'd0;

    typedef struct {
        logic          id;
        logic          err;
        logic [EW-1:0] data;
        int            cnt;
    } exp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    pq_share_ctrl_if #(.EW(EW), .CW(CW)) bus ();

    pq_share_ctrl #(
        .DEPTH     (DEPTH),
        .EW        (EW),
        .CW        (CW),
        .PQ_IDLE_ST(IDLE_ST),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .system1000     (clk),
        .system1000_rstn(rstn),
        .bus            (bus)
    );

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    bit            a_pend = 0, b_pend = 0;
    int            a_left = 0, b_left = 0;
    logic          a_op = 0, b_op = 0;
    logic [EW-1:0] a_dat = '0, b_dat = '0;

    // queue model: sorted contents, busy time after each command
    int            q_lat = 1;
    int            busy_left = 0;
    bit            stuck = 0;
    logic [EW-1:0] mq[$];

    exp_t          exp_q[$];
    int            exp_count = 0;
    int            grant_log[$];
    int            acc_cyc = -1, cmd_cyc = -1, rsp_cyc = -1;
    int            ins_cnt = 0, del_cnt = 0;
    logic [EW+1:0] last_cmd = '0;
    logic          last_id = 0, last_err = 0;
    logic [EW-1:0] last_data = '0;
    bit            cnt_chk = 0;
    int            cnt_exp = 0;

    task automatic apply_req();
        bus.a_valid_i = a_pend;
        bus.a_op_i    = a_op;
        bus.a_data_i  = a_dat;
        bus.b_valid_i = b_pend;
        bus.b_op_i    = b_op;
        bus.b_data_i  = b_dat;
    endtask

    task automatic drive_inputs();
        apply_req();
        bus.pq_st_i = (busy_left > 0) ? 3'd1 : IDLE_ST;
        if (busy_left > 0) busy_left--;
        bus.pq_head_i = (mq.size() > 0) ? {1'b1, mq[0]} : '0;
    endtask

    task automatic model_insert(input logic [EW-1:0] e);
        int i = 0;
        while (i < mq.size() && mq[i] <= e) i++;
        mq.insert(i, e);
    endtask

    task automatic accept(input logic id, input logic op, input logic [EW-1:0] d,
                          input logic [EW:0] head);
        exp_t e;
        e.id = id;
        if (op) e.err = (exp_count == 0) || !head[EW];
        else    e.err = (exp_count == DEPTH);
        if (stuck) e.err = 1'b1;
        e.data = e.err ? '0 : (op ? head[EW-1:0] : d);
        if (!e.err) exp_count = op ? exp_count - 1 : exp_count + 1;
        e.cnt = exp_count;
        exp_q.push_back(e);
        grant_log.push_back(int'(id));
        acc_cyc = cyc;
    endtask

    // One clock: sample just after the negedge, advance, drive at next negedge.
    task automatic tick();
        logic [EW:0] head;
        exp_t        e;
        #1;
        head = bus.pq_head_i;
        if (cnt_chk) begin
            checks++;
            if (bus.count_o !== CW'(cnt_exp)) begin
                fails++;
                $display("FAIL count_after_rsp: got %0d expected %0d", bus.count_o, cnt_exp);
            end
            cnt_chk = 0;
        end
        if (bus.a_ready_o && bus.b_ready_o) begin
            checks++;
            fails++;
            $display("FAIL one_ready: got a_ready=1 b_ready=1 expected at most one");
        end
        if (bus.rsp_valid_o) begin
            rsp_cyc   = cyc;
            last_id   = bus.rsp_id_o;
            last_err  = bus.rsp_err_o;
            last_data = bus.rsp_data_o;
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_rsp: got id=%0d err=%0d expected no response",
                         bus.rsp_id_o, bus.rsp_err_o);
            end else begin
                e = exp_q.pop_front();
                if ({bus.rsp_id_o, bus.rsp_err_o, bus.rsp_data_o} !== {e.id, e.err, e.data}) begin
                    fails++;
                    $display("FAIL rsp: got id=%0d err=%0d data=%h expected id=%0d err=%0d data=%h",
                             bus.rsp_id_o, bus.rsp_err_o, bus.rsp_data_o, e.id, e.err, e.data);
                end
                cnt_chk = 1;
                cnt_exp = e.cnt;
            end
        end
        if (bus.a_ready_o && a_pend) begin
            accept(1'b0, a_op, a_dat, head);
            a_left--;
            a_pend = (a_left > 0);
            a_dat  = a_dat + 1;
        end else if (bus.b_ready_o && b_pend) begin
            accept(1'b1, b_op, b_dat, head);
            b_left--;
            b_pend = (b_left > 0);
            b_dat  = b_dat + 1;
        end
        case (bus.pq_cmd_o[EW+1:EW])
            2'b01: begin
                model_insert(bus.pq_cmd_o[EW-1:0]);
                ins_cnt++;
                busy_left = stuck ? 1000000 : q_lat;
                cmd_cyc   = cyc;
                last_cmd  = bus.pq_cmd_o;
            end
            2'b10: begin
                if (mq.size() > 0) mq.delete(0);
                del_cnt++;
                busy_left = stuck ? 1000000 : q_lat;
                cmd_cyc   = cyc;
                last_cmd  = bus.pq_cmd_o;
            end
            default: ;
        endcase
        @(posedge clk);
        cyc++;
        @(negedge clk);
        drive_inputs();
    endtask

    task automatic run(input int budget);
        int n = 0;
        bit busy;
        busy = a_pend || b_pend || (exp_q.size() > 0) || cnt_chk;
        while (busy && n < budget) begin
            tick();
            n++;
            busy = a_pend || b_pend || (exp_q.size() > 0) || cnt_chk;
        end
        checks++;
        if (busy) begin
            fails++;
            $display("FAIL run_budget: got still busy after %0d cycles expected completion", n);
        end
    endtask

    task automatic req_a(input logic op, input logic [EW-1:0] d, input int n);
        a_op = op; a_dat = d; a_left = n; a_pend = 1; apply_req();
    endtask

    task automatic req_b(input logic op, input logic [EW-1:0] d, input int n);
        b_op = op; b_dat = d; b_left = n; b_pend = 1; apply_req();
    endtask

    task automatic clear_model();
        a_pend = 0; b_pend = 0; a_left = 0; b_left = 0; stuck = 0; busy_left = 0;
        mq.delete(); exp_q.delete(); grant_log.delete(); exp_count = 0; cnt_chk = 0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        clear_model();
        drive_inputs();
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        drive_inputs();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        req_a(1'b0, 65'h1, 1);
        #1;
        checks++;
        if (bus.a_ready_o !== 1'b0) begin
            fails++; $display("FAIL reset_ready: got %b expected 0", bus.a_ready_o);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.rsp_valid_o !== 1'b0) begin
            fails++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid_o);
        end
        checks++;
        if (bus.rsp_data_o !== '0) begin
            fails++; $display("FAIL reset_rsp_data: got %h expected 0", bus.rsp_data_o);
        end
        checks++;
        if (bus.pq_cmd_o !== '0) begin
            fails++; $display("FAIL reset_cmd: got %h expected 0", bus.pq_cmd_o);
        end
        checks++;
        if (bus.count_o !== '0) begin
            fails++; $display("FAIL reset_count: got %0d expected 0", bus.count_o);
        end
        @(negedge clk);
        do_reset();
    endtask

    task automatic test_single_push();
        int start;
        q_lat = 3;
        start = cyc;
        req_a(1'b0, 65'h1_0000_0005, 1);
        run(50);
        checks++;
        if (acc_cyc != start) begin
            fails++; $display("FAIL push_ready_cycle: got %0d expected %0d", acc_cyc - start, 0);
        end
        checks++;
        if (cmd_cyc != start + 1) begin
            fails++; $display("FAIL push_cmd_cycle: got %0d expected 1", cmd_cyc - start);
        end
        checks++;
        if (last_cmd !== {2'b01, 65'h1_0000_0005}) begin
            fails++; $display("FAIL push_cmd: got %h expected %h", last_cmd, {2'b01, 65'h1_0000_0005});
        end
        checks++;
        if (rsp_cyc != start + 6) begin
            fails++; $display("FAIL push_rsp_cycle: got %0d expected 6", rsp_cyc - start);
        end
        checks++;
        if ({last_id, last_err, last_data} !== {1'b0, 1'b0, 65'h1_0000_0005}) begin
            fails++; $display("FAIL push_rsp: got id=%0d err=%0d data=%h expected 0 0 100000005",
                              last_id, last_err, last_data);
        end
        checks++;
        if (bus.count_o !== CW'(1)) begin
            fails++; $display("FAIL push_count: got %0d expected 1", bus.count_o);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        q_lat = 2;
        req_a(1'b0, 65'h10, 2);
        req_b(1'b0, 65'h20, 1);
        run(100);
        checks++;
        if (grant_log.size() != 3 || grant_log[0] != 0 || grant_log[1] != 1 || grant_log[2] != 0)
        begin
            fails++; $display("FAIL rr_order: got %p expected '{0,1,0}", grant_log);
        end
        checks++;
        if (bus.count_o !== CW'(3)) begin
            fails++; $display("FAIL rr_count: got %0d expected 3", bus.count_o);
        end
    endtask

    task automatic test_pop();
        do_reset();
        q_lat = 1;
        req_a(1'b0, 65'h5, 1); run(50);
        req_a(1'b0, 65'h2, 1); run(50);
        req_a(1'b0, 65'h9, 1); run(50);
        checks++;
        if (bus.count_o !== CW'(3)) begin
            fails++; $display("FAIL pop_pre_count: got %0d expected 3", bus.count_o);
        end
        req_b(1'b1, '0, 1);
        run(50);
        checks++;
        if ({last_id, last_err, last_data} !== {1'b1, 1'b0, 65'h2}) begin
            fails++; $display("FAIL pop_rsp: got id=%0d err=%0d data=%h expected 1 0 2",
                              last_id, last_err, last_data);
        end
        checks++;
        if (last_cmd !== {2'b10, {EW{1'b0}}}) begin
            fails++; $display("FAIL pop_cmd: got %h expected delete-min", last_cmd);
        end
        checks++;
        if (bus.count_o !== CW'(2)) begin
            fails++; $display("FAIL pop_count: got %0d expected 2", bus.count_o);
        end
    endtask

    task automatic test_empty_full();
        int d0, i0;
        do_reset();
        q_lat = 1;
        d0 = del_cnt;
        req_a(1'b1, '0, 1);
        run(50);
        checks++;
        if (del_cnt != d0) begin
            fails++; $display("FAIL empty_no_cmd: got %0d deletes expected 0", del_cnt - d0);
        end
        checks++;
        if ({last_err, last_data} !== {1'b1, {EW{1'b0}}}) begin
            fails++; $display("FAIL empty_rsp: got err=%0d data=%h expected err=1 data=0",
                              last_err, last_data);
        end
        req_a(1'b0, 65'h100, DEPTH);
        run(DEPTH * 8);
        checks++;
        if (bus.count_o !== CW'(DEPTH)) begin
            fails++; $display("FAIL fill_count: got %0d expected %0d", bus.count_o, DEPTH);
        end
        i0 = ins_cnt;
        req_b(1'b0, 65'h7, 1);
        run(50);
        checks++;
        if (ins_cnt != i0) begin
            fails++; $display("FAIL full_no_cmd: got %0d inserts expected 0", ins_cnt - i0);
        end
        checks++;
        if ({last_id, last_err, last_data} !== {1'b1, 1'b1, {EW{1'b0}}}) begin
            fails++; $display("FAIL full_rsp: got id=%0d err=%0d data=%h expected 1 1 0",
                              last_id, last_err, last_data);
        end
        checks++;
        if (bus.count_o !== CW'(DEPTH)) begin
            fails++; $display("FAIL full_count: got %0d expected %0d", bus.count_o, DEPTH);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        q_lat = 1;
        stuck = 1;
        req_a(1'b0, 65'h33, 1);
        run(TIMEOUT + 50);
        stuck = 0;
        checks++;
        if (rsp_cyc - cmd_cyc != TIMEOUT + 1) begin
            fails++; $display("FAIL timeout_cycles: got %0d wait cycles expected %0d",
                              rsp_cyc - cmd_cyc - 1, TIMEOUT);
        end
        checks++;
        if (last_err !== 1'b1) begin
            fails++; $display("FAIL timeout_err: got %b expected 1", last_err);
        end
        checks++;
        if (bus.count_o !== '0) begin
            fails++; $display("FAIL timeout_count: got %0d expected 0", bus.count_o);
        end
    endtask

    task automatic test_reset_mid_wait();
        int n = 0;
        int rst_cyc;
        do_reset();
        q_lat = 1;
        req_a(1'b0, 65'h40, 1);
        run(50);
        stuck = 1;
        cmd_cyc = -1;
        req_a(1'b0, 65'h41, 1);
        while (!(cmd_cyc >= 0 && cyc >= cmd_cyc + 3) && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (cmd_cyc < 0) begin
            fails++; $display("FAIL midwait_issue: got no command expected insert");
        end
        rstn = 1'b0;
        #1;
        checks++;
        if ({bus.rsp_valid_o, bus.rsp_err_o, bus.a_ready_o, bus.b_ready_o} !== 4'b0) begin
            fails++; $display("FAIL midwait_strobes: got %b expected 0000",
                              {bus.rsp_valid_o, bus.rsp_err_o, bus.a_ready_o, bus.b_ready_o});
        end
        checks++;
        if (bus.pq_cmd_o !== '0 || bus.rsp_data_o !== '0) begin
            fails++; $display("FAIL midwait_bus: got cmd=%h data=%h expected 0 0",
                              bus.pq_cmd_o, bus.rsp_data_o);
        end
        checks++;
        if (bus.count_o !== '0) begin
            fails++; $display("FAIL midwait_count: got %0d expected 0", bus.count_o);
        end
        clear_model();
        drive_inputs();
        rst_cyc = cyc;
        repeat (3) tick();
        checks++;
        if (rsp_cyc >= rst_cyc) begin
            fails++; $display("FAIL midwait_no_rsp: got response at cycle %0d expected none", rsp_cyc);
        end
        rstn = 1'b1;
        req_a(1'b0, 65'h50, 1);
        req_b(1'b0, 65'h60, 1);
        run(100);
        checks++;
        if (grant_log.size() != 2 || grant_log[0] != 0) begin
            fails++; $display("FAIL post_reset_tie: got %p expected A first", grant_log);
        end
        checks++;
        if (bus.count_o !== CW'(2)) begin
            fails++; $display("FAIL post_reset_count: got %0d expected 2", bus.count_o);
        end
    endtask

    initial begin
        drive_inputs();
        @(negedge clk);
        test_reset();
        test_single_push();
        test_round_robin();
        test_pop();
        test_empty_full();
        test_timeout();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/pq_share_ctrl.md
Name: pq_share_ctrl

Overview:
- Controller and arbiter sharing one priority-queue datapath between two requesters (A, B).
- Requesters are e.g. the path-expansion engine and the result-drain logic.
- Accepts push/pop requests, issues one queue command at a time, waits for the queue to return to idle, returns a tagged response.
- Tracks occupancy so push-when-full and pop-when-empty are rejected without touching the queue.

Parameters:
- DEPTH, 1000, queue capacity in entries
- EW, 65, entry width
- CW, 10, occupancy counter width (holds 0..DEPTH)
- PQ_IDLE_ST, 3'd0, value of pq_st_i meaning the queue is idle
- TIMEOUT, 255, maximum WAIT cycles before an error response

Ports:
- system1000  in  1  clock
- system1000_rstn  in  1  reset, asynchronous, active-low
- a_valid_i  in  1  requester A request valid
- a_op_i  in  1  0 = push, 1 = pop
- a_data_i  in  EW  entry to push (ignored for pop)
- a_ready_o  out  1  A request accepted this cycle when a_valid_i is also high
- b_valid_i, b_op_i, b_data_i, b_ready_o: as A, for requester B
- rsp_valid_o  out  1  one-cycle response strobe
- rsp_id_o  out  1  0 = A, 1 = B
- rsp_err_o  out  1  request rejected (full, empty or timeout)
- rsp_data_o  out  EW  popped entry, or echoed push entry; 0 on error
- pq_cmd_o  out  EW+2  {op[1:0], entry}; op 00 = NOP, 01 = INSERT, 10 = DELETE-MIN
- pq_st_i  in  3  queue state
- pq_head_i  in  EW+1  {valid, head entry}
- count_o  out  CW  current occupancy

Behaviour:
- Clocking: one clock; reset is asynchronous and active-low on system1000_rstn; all state registered on posedge system1000.
- Reset values: FSM = IDLE, count = 0, last_grant = B (so A wins the first tie), pq_cmd_o = NOP, all ready/rsp outputs 0, rsp_data_o = 0.
- States:
  - IDLE:
    - Arbitrate when pq_st_i == PQ_IDLE_ST.
    - Single valid requester: grant it.
    - Both valid: grant the requester that is not last_grant (round-robin).
    - x_ready_o = (state == IDLE) & (pq_st_i == PQ_IDLE_ST) & grant_x. Combinational; at most one ready high.
    - On accept, latch id, op, data and pq_head_i, and update last_grant.
    - Push with count == DEPTH, or pop with count == 0: go to RESP with err = 1; no queue command.
    - Otherwise go to ISSUE.
  - ISSUE (1 cycle): pq_cmd_o = INSERT {01, data} or DELETE-MIN {10, 0}; go to WAIT. pq_cmd_o is NOP in every other state.
  - WAIT:
    - Stay at least 1 cycle; increment the wait counter.
    - pq_st_i == PQ_IDLE_ST: go to RESP, err = 0.
    - Wait counter reaches TIMEOUT: go to RESP, err = 1; count is not changed.
  - RESP (1 cycle):
    - rsp_valid_o = 1 with the latched id and err.
    - Pop: rsp_data_o = latched head entry, i.e. the pre-delete minimum.
    - Push: rsp_data_o = echoed entry.
    - Error: rsp_data_o = 0.
    - Count update when err = 0: push +1, pop -1.
    - Pop with count > 0 but latched head valid bit = 0: err = 1, count unchanged.
    - Next state IDLE.
- Throughput: minimum 4 cycles per request (IDLE → ISSUE → WAIT → RESP); a new accept is possible in the cycle after RESP.
- Requests are not queued internally. A requester holds valid, op and data until it sees ready.
- Requests arriving in ISSUE/WAIT/RESP see ready = 0.
- count never wraps: saturates at 0 and DEPTH by construction (checked before issue).
- count_o mirrors count.
- Reset asserted mid-operation: immediate return to reset values. The queue shares the same reset, so count = 0 stays consistent. No response is emitted for the aborted request.

Test Plan:
- Reset, then A push entry 0x1_0000_0005 (queue idles after 3 cycles) → a_ready_o at cycle 0, pq_cmd_o = {01, entry} at cycle 1, rsp_valid_o with id = 0, err = 0, data = entry; count_o = 1.
- A and B both valid with pushes, held 3 rounds → grant order A, B, A; each rsp_id_o matches; count_o = 3.
- Push 5, 2, 9, then B pop with pq_head_i = entry 2 → rsp_data_o = entry 2, id = 1, count_o decrements 3 → 2.
- Pop at count 0 → no DELETE-MIN issued, rsp_err_o = 1, data = 0, count_o = 0. Force count = DEPTH with 1000 pushes, then push → err = 1, count_o stays 1000.
- pq_st_i held non-idle after ISSUE → rsp_err_o = 1 exactly TIMEOUT cycles into WAIT; count_o unchanged.
- Assert system1000_rstn = 0 during WAIT → outputs go to reset values immediately, no rsp_valid_o; after release, A is granted first on a tie.
